// File: rtl/rv32i_pkg.sv
// rv32i_pkg
//   Shared definitions for the RV32I core slice: data width, register
//   address width, the word/address types, and the register-file FSM
//   state encoding.
package rv32i_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // RF_CLEAR: zeroing sweep in progress, RF_RUN: normal operation.
  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;

endpackage

// File: rtl/rv32i_regfile_mem.sv
// rv32i_regfile_mem
//   Reset-free NREGS x XLEN storage array with one synchronous write port
//   and three asynchronous read ports. It has no reset, so synthesis can
//   map it to distributed/LUT RAM. The storage style can be swapped per
//   target without touching the control logic in rv32i_regfile.
//
// Ports
//   clk       in   write clock, rising edge
//   we_i      in   write enable
//   waddr_i   in   write address
//   wdata_i   in   write data
//   raddr1_i  in   read address, port 1   -> rdata1_o (combinational)
//   raddr2_i  in   read address, port 2   -> rdata2_o (combinational)
//   raddr3_i  in   read address, port 3   -> rdata3_o (combinational)
module rv32i_regfile_mem #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  input  logic [ADDR_W-1:0] raddr3_i,
  output logic [XLEN-1:0]   rdata1_o,
  output logic [XLEN-1:0]   rdata2_o,
  output logic [XLEN-1:0]   rdata3_o
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem_q[raddr1_i];
  assign rdata2_o = mem_q[raddr2_i];
  assign rdata3_o = mem_q[raddr3_i];

endmodule

// File: rtl/rv32i_regfile.sv
// rv32i_regfile
//   RV32I architectural integer register file: NREGS x XLEN registers,
//   one write-back port, two registered read ports, and one combinational
//   debug read port. After reset, or on clear_req, a sweep zeroes one
//   register per cycle before the file accepts traffic.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-low reset
//   wb_enable  in   write strobe (honoured only while ready)
//   wb_reg     in   write address (x0 writes are discarded)
//   wb_data    in   write data
//   rs1_reg    in   read address, port 1
//   rs2_reg    in   read address, port 2
//   clear_req  in   single-cycle request to re-run the clear sweep
//   rs1_data   out  registered read data, port 1 (1-cycle latency)
//   rs2_data   out  registered read data, port 2 (1-cycle latency)
//   ready      out  high in RF_RUN
//   dbg_reg    in   debug read address
//   dbg_data   out  combinational debug read data (not gated by state)
//
// Handshake: there is no backpressure. A write is accepted on a rising
// edge only when ready is high at that edge and clear_req is low; any
// other write is dropped, never queued. Read data sampled at an edge is
// valid only when ready was high at that edge, otherwise it loads 0.
module rv32i_regfile
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN   = rv32i_pkg::XLEN,
  parameter int unsigned NREGS  = 32,
  parameter int unsigned BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_enable,
  input  logic [$clog2(NREGS)-1:0] wb_reg,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [$clog2(NREGS)-1:0] rs1_reg,
  input  logic [$clog2(NREGS)-1:0] rs2_reg,
  input  logic                     clear_req,
  output logic [XLEN-1:0]          rs1_data,
  output logic [XLEN-1:0]          rs2_data,
  output logic                     ready,
  input  logic [$clog2(NREGS)-1:0] dbg_reg,
  output logic [XLEN-1:0]          dbg_data
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_t       state_q;
  logic [AW-1:0]   clr_idx_q;
  logic            ready_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] rs1_d, rs2_d;

  logic            run_wr;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rd1, mem_rd2, mem_rd3;

  // An architectural write happens only in RUN, never to x0, and never on
  // the edge that starts a clear sweep (the clear wins).
  always_comb begin
    run_wr = (state_q == RF_RUN) && wb_enable && (wb_reg != '0) && !clear_req;
  end

  // The sweep owns the write port while clearing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wb_reg;
    mem_wdata = wb_data;
    if (state_q == RF_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_idx_q;
      mem_wdata = '0;
    end else if (run_wr) begin
      mem_we = 1'b1;
    end
  end

  rv32i_regfile_mem #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .ADDR_W(AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .raddr1_i(rs1_reg),
    .raddr2_i(rs2_reg),
    .raddr3_i(dbg_reg),
    .rdata1_o(mem_rd1),
    .rdata2_o(mem_rd2),
    .rdata3_o(mem_rd3)
  );

  // Read-port next values: x0 reads as zero; with BYPASS the value being
  // written this edge is forwarded so both ports see the new data.
  always_comb begin
    rs1_d = '0;
    rs2_d = '0;
    if (state_q == RF_RUN) begin
      if (rs1_reg != '0) begin
        if ((BYPASS != 0) && run_wr && (wb_reg == rs1_reg)) rs1_d = wb_data;
        else                                                 rs1_d = mem_rd1;
      end
      if (rs2_reg != '0) begin
        if ((BYPASS != 0) && run_wr && (wb_reg == rs2_reg)) rs2_d = wb_data;
        else                                                 rs2_d = mem_rd2;
      end
    end
  end

  // FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RF_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else begin
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      case (state_q)
        RF_CLEAR: begin
          if (clear_req) begin
            clr_idx_q <= '0;
          end else if (clr_idx_q == LAST_IDX) begin
            state_q   <= RF_RUN;
            ready_q   <= 1'b1;
            clr_idx_q <= '0;
          end else begin
            clr_idx_q <= clr_idx_q + 1'b1;
          end
        end
        RF_RUN: begin
          if (clear_req) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
          end
        end
        default: begin
          state_q   <= RF_CLEAR;
          clr_idx_q <= '0;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rs1_data = rs1_q;
  assign rs2_data = rs2_q;
  assign ready    = ready_q;
  assign dbg_data = (dbg_reg == '0) ? '0 : mem_rd3;

endmodule

// File: doc/rv32i_regfile.md
# rv32i_regfile

Architectural integer register file for the RV32I core: 32 × 32-bit registers, one write-back port, two registered read ports, and one asynchronous debug read port for board display. After reset, or on request, a clear sequencer zeroes every register one per cycle. Storage stays reset-free so it can infer block/LUT RAM. The decode stage drives `rs1_reg`/`rs2_reg`, and the write-back stage drives `wb_enable`/`wb_reg`/`wb_data`.

## Interface
- `XLEN`, 32, data width
- `NREGS`, 32, register count (power of two; address width = log2(NREGS))
- `BYPASS`, 1, 1 = same-cycle write-to-read forwarding into registered read data
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `wb_enable`  in  1  write strobe
- `wb_reg`  in  5  write address
- `wb_data`  in  32  write data
- `rs1_reg`  in  5  read port 1 address
- `rs2_reg`  in  5  read port 2 address
- `clear_req`  in  1  single-cycle request to re-run the clear sweep
- `rs1_data`  out  32  registered read data, port 1
- `rs2_data`  out  32  registered read data, port 2
- `ready`  out  1  high when in RUN (writes accepted, reads valid)
- `dbg_reg`  in  5  debug read address
- `dbg_data`  out  32  combinational debug read data

## Operation
- FSM states: `RF_CLEAR`, `RF_RUN`.
- While `reset` is low:
  - state = `RF_CLEAR`, `clr_idx` = 0
  - `ready` = 0, `rs1_data` = `rs2_data` = 0
  - Storage is not reset.
- `RF_CLEAR`:
  - Each rising edge writes 0 to `mem[clr_idx]` and increments `clr_idx`.
  - On the edge that writes index NREGS−1, go to `RF_RUN` and set `ready` = 1.
  - `wb_enable` is ignored; writes are dropped, not queued.
  - `rs1_data`/`rs2_data` load 0 every edge.
- `RF_RUN`:
  - `wb_enable`=1 with `wb_reg`≠0 writes `wb_data` to `mem[wb_reg]` on the edge.
  - Writes to x0 are discarded.
- `clear_req`:
  - Sampled on the edge. In `RF_RUN`, it moves to `RF_CLEAR`, sets `clr_idx` = 0 and `ready` = 0.
  - A write presented on that same edge is dropped.
  - In `RF_CLEAR`, it restarts the sweep at `clr_idx` = 0.
- Read port n, each edge in `RF_RUN`:
  - `rsn_reg` = 0 → load 0.
  - Else, if BYPASS=1 and `wb_enable` and `wb_reg`==`rsn_reg` → load `wb_data` (new value).
  - Else → load `mem[rsn_reg]`; with BYPASS=0 this is the old value on a collision.
- `dbg_data`: `dbg_reg`=0 → 0, else `mem[dbg_reg]`. It is purely combinational and is not gated by state, so it shows partially cleared contents during a sweep.

## Timing
- Read latency: 1 cycle. Address presented before edge k appears on `rsn_data` after edge k.
- Write latency: 1 cycle. A write on edge k is visible through `mem` on reads sampled at edge k+1. With BYPASS=1 it is also visible on edge k itself.
- Clear sweep: exactly NREGS edges (32) from the first edge after reset release to `ready` high. `ready` is asserted after the 32nd edge.
- Reset release is asynchronous to the design; the first active edge is the first `clk` rise with `reset` high.
- Reset asserted mid-sweep or mid-run: outputs go to reset values immediately, without waiting for a clock edge. On release, the sweep restarts from index 0.
- Simultaneous `wb_enable` and `clear_req` in `RF_RUN`: the clear wins and the write is dropped.
- Both read ports addressing the same register, including the write target, return identical data.

## Structure
- Shared package `rv32i_pkg` holds:
  - `XLEN`
  - `REG_ADDR_W` (5)
  - `typedef logic [XLEN-1:0] word_t`
  - `typedef logic [REG_ADDR_W-1:0] reg_addr_t`
  - `typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t`
- Sub-module `rv32i_regfile_mem`: reset-free NREGS×XLEN array with one write port and three asynchronous read ports, so the storage style can be swapped per target.
- FSM, clear counter, x0 masking, bypass and output registers live in `rv32i_regfile`.

## Test plan
- **Reset sweep.** Release reset and count edges → `ready`=0 for 31 edges and rises after the 32nd. Reading x1..x31 then returns 0x0 on both ports.
- **Basic write/read.** Write 0x25 to x10; next cycle set rs1=x10, rs2=x15 → `rs1_data`=0x25, `rs2_data`=0x0 one cycle later.
- **x0 protection.** Write 321 (0x141) to x0 with rs1=x0, rs2=x10 (holding 0x25) → `rs1_data`=0, `rs2_data`=0x25. `dbg_data` at `dbg_reg`=0 is 0.
- **Bypass collision.** x5 holds 0x20; write 0x99 to x5 on the same edge that rs1=rs2=x5 is sampled:
  - BYPASS=1 → both ports read 0x99.
  - BYPASS=0 → both ports read 0x20, then 0x99 on the next edge.
- **Clear request with concurrent write.** With x7=0xDEAD, assert `clear_req` and a write of 0x1234 to x8 on the same edge:
  - `ready` drops.
  - After 32 edges, x7=0 and x8=0.
  - `wb_enable` pulses during the sweep leave all registers at 0.
- **Async reset mid-operation.** Assert `reset` low between edges during RUN → `rs1_data`/`rs2_data`/`ready` go to 0 before the next edge, and a full 32-cycle sweep follows release.
